// File: rtl/div_pkg.sv
// Shared types and elaboration helpers for the sub-and-shift divider.
package div_pkg;

    // Controller states; DONE holds a result until the consumer takes it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Widest operand the MIN helper can describe.
    localparam int MAX_W = 128;

    // Number of CALC cycles for a given width and step count.
    function automatic int iter_f(input int data_w, input int step_bits);
        return data_w / step_bits;
    endfunction

    // Counter width; it must be able to hold the value ITER.
    function automatic int cnt_w_f(input int data_w, input int step_bits);
        return $clog2(iter_f(data_w, step_bits) + 1);
    endfunction

    // Most negative two's complement value of width data_w, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] min_f(input int data_w);
        logic [MAX_W-1:0] m;
        m = '0;
        m[data_w-1] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/div_subshift_hs_if.sv
// Request/response handshake bundle between a divide client and the divider.
interface div_subshift_hs_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              div_by_zero;
    logic              overflow;

    modport master (
        output in_valid, in_sign, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, in_sign, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_subshift_step.sv
// One restoring division step on the {rem,quo} pair (purely combinational).
module div_subshift_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);
    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] trial;
    logic              borrow;
    logic              unused_trial_msb;

    // Shift the pair left, trial-subtract the divisor, restore on borrow.
    always_comb begin
        shifted = {rem_i, quo_i[DATA_W-1]};
        // The shifted remainder needs DATA_W+1 bits; the extra top bit is the borrow.
        trial   = {1'b0, shifted} - {2'b00, dvs_i};
        borrow  = trial[DATA_W+1];
        rem_o   = borrow ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_o   = {quo_i[DATA_W-2:0], ~borrow};
    end

    // Without a borrow the difference is below the divisor, so this bit is always 0.
    assign unused_trial_msb = trial[DATA_W];

endmodule

// File: rtl/div_subshift_hs.sv
// Iterative restoring divider with valid/ready handshake, signed/unsigned modes,
// early completion for divide-by-zero and MIN/-1, and a synchronous abort.
module div_subshift_hs
    import div_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int STEP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    div_subshift_hs_if.slave  bus
);
    localparam int                ITER   = iter_f(DATA_W, STEP_BITS);
    localparam int                CNT_W  = cnt_w_f(DATA_W, STEP_BITS);
    localparam logic [CNT_W-1:0]  ITER_C = CNT_W'(ITER);
    localparam logic [CNT_W-1:0]  ONE_C  = CNT_W'(1);
    localparam logic [DATA_W-1:0] MIN_C  = DATA_W'(min_f(DATA_W));

    div_state_e        state_q, state_d;
    logic              in_ready, out_valid, accept;

    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] remd_q, remd_d;
    logic              dbz_q, dbz_d;
    logic              ovf_q, ovf_d;

    logic              div_zero, sgn_ovf;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    logic [DATA_W-1:0] rem_c [STEP_BITS+1];
    logic [DATA_W-1:0] quo_c [STEP_BITS+1];

    // Decode special cases and operand magnitudes from the live request.
    always_comb begin
        div_zero = (bus.divisor == '0);
        sgn_ovf  = bus.in_sign && (bus.dividend == MIN_C) && (bus.divisor == '1);
        a_neg    = bus.in_sign & bus.dividend[DATA_W-1];
        b_neg    = bus.in_sign & bus.divisor[DATA_W-1];
        // |MIN| wraps to 2^(DATA_W-1), which is exact when read as unsigned.
        a_mag    = a_neg ? -bus.dividend : bus.dividend;
        b_mag    = b_neg ? -bus.divisor  : bus.divisor;
    end

    // STEP_BITS chained restoring steps resolve that many quotient bits per CALC cycle.
    assign rem_c[0] = rem_q;
    assign quo_c[0] = quo_q;
    for (genvar g = 0; g < STEP_BITS; g++) begin : g_step
        div_subshift_step #(.DATA_W(DATA_W)) u_step (
            .rem_i (rem_c[g]),
            .quo_i (quo_c[g]),
            .dvs_i (dvs_q),
            .rem_o (rem_c[g+1]),
            .quo_o (quo_c[g+1])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; clear overrides everything.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_d = (div_zero || sgn_ovf) ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt_q == ONE_C) state_d = ST_FIX;
                ST_FIX:  state_d = ST_DONE;
                ST_DONE: begin
                    if (accept)             state_d = (div_zero || sgn_ovf) ? ST_DONE : ST_CALC;
                    else if (bus.out_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs; clear suppresses ready so a client never sees a phantom accept.
    always_comb begin
        in_ready  = !clear && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));
        out_valid = (state_q == ST_DONE);
        accept    = bus.in_valid && in_ready;
    end

    // Datapath next-state: load on accept, iterate in CALC, sign-correct in FIX.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        if (clear) begin
            cnt_d  = '0;
            quot_d = '0;
            remd_d = '0;
            dbz_d  = 1'b0;
            ovf_d  = 1'b0;
        end else if (accept) begin
            quot_d = '0;
            remd_d = '0;
            dbz_d  = 1'b0;
            ovf_d  = 1'b0;
            if (div_zero) begin
                quot_d = '1;
                remd_d = bus.dividend;
                dbz_d  = 1'b1;
            end else if (sgn_ovf) begin
                quot_d = MIN_C;
                ovf_d  = 1'b1;
            end else begin
                rem_d   = '0;
                quo_d   = a_mag;
                dvs_d   = b_mag;
                q_neg_d = a_neg ^ b_neg;
                r_neg_d = a_neg;
                cnt_d   = ITER_C;
            end
        end else if (state_q == ST_CALC) begin
            rem_d = rem_c[STEP_BITS];
            quo_d = quo_c[STEP_BITS];
            cnt_d = cnt_q - ONE_C;
        end else if (state_q == ST_FIX) begin
            quot_d = q_neg_q ? -quo_q : quo_q;
            remd_d = r_neg_q ? -rem_q : rem_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remd_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule
